// File: rtl/complex_alu.sv
// Sequential complex ALU feeding the register bank write port: one shared signed
// 32x32 multiplier, time-multiplexed over MUL (4 products) and MAG2 (2 products).
module complex_alu #(
  parameter int FRAC = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [63:0] opA,
  input  logic [63:0] opB,
  input  logic [3:0]  dsel,
  output logic        busy,
  output logic        done,
  output logic        wen,
  output logic [3:0]  wsel,
  output logic [63:0] result,
  output logic        ovf
);

  typedef enum logic [2:0] {IDLE, EXEC, MUL0, MUL1, MUL2, MUL3, SQ0, SQ1} state_t;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_MUL  = 3'b010;
  localparam logic [2:0] OP_CONJ = 3'b011;
  localparam logic [2:0] OP_MAG2 = 3'b100;
  localparam logic [2:0] OP_NEG  = 3'b101;

  state_t             state, state_nxt;
  logic [2:0]         op_q;
  logic signed [31:0] ar, ai, br, bi;
  logic signed [65:0] acc_re, acc_im, re_nxt, im_nxt, prod_ext;
  logic signed [31:0] mul_x, mul_y;
  logic signed [63:0] prod;
  logic [32:0]        ex_re, ex_im, fin_re, fin_im;

  // {overflow, value}: accumulator scaled by FRAC (floor) and checked for signed 32-bit range
  function automatic logic [32:0] scale_fit(input logic signed [65:0] acc);
    logic signed [65:0] sh;
    sh = acc >>> FRAC;
    return {(sh[65:31] != {35{sh[31]}}), sh[31:0]};
  endfunction

  function automatic logic [32:0] negate(input logic signed [31:0] x);
    logic signed [31:0] n;
    n = -x;
    return {(x == 32'sh8000_0000), n};
  endfunction

  function automatic logic [32:0] add_sub(input logic signed [31:0] a,
                                          input logic signed [31:0] b,
                                          input logic sub);
    logic signed [31:0] s;
    logic               v;
    s = sub ? (a - b) : (a + b);
    v = sub ? ((a[31] != b[31]) && (s[31] != a[31]))
            : ((a[31] == b[31]) && (s[31] != a[31]));
    return {v, s};
  endfunction

  // Operand selection for the shared multiplier follows the product schedule
  always_comb begin
    mul_x = ar;
    mul_y = br;
    case (state)
      MUL1:    begin mul_x = ai; mul_y = bi; end
      MUL2:    begin mul_x = ar; mul_y = bi; end
      MUL3:    begin mul_x = ai; mul_y = br; end
      SQ0:     begin mul_x = ar; mul_y = ar; end
      SQ1:     begin mul_x = ai; mul_y = ai; end
      default: ;
    endcase
  end

  assign prod     = mul_x * mul_y;
  assign prod_ext = {{2{prod[63]}}, prod};

  always_comb begin
    re_nxt = acc_re;
    im_nxt = acc_im;
    case (state)
      MUL0, SQ0, SQ1: re_nxt = acc_re + prod_ext;
      MUL1:           re_nxt = acc_re - prod_ext;
      MUL2, MUL3:     im_nxt = acc_im + prod_ext;
      default: ;
    endcase
  end

  assign fin_re = scale_fit(re_nxt);
  assign fin_im = scale_fit(im_nxt);

  always_comb begin
    ex_re = {1'b0, ar};
    ex_im = {1'b0, ai};
    case (op_q)
      OP_ADD:  begin ex_re = add_sub(ar, br, 1'b0); ex_im = add_sub(ai, bi, 1'b0); end
      OP_SUB:  begin ex_re = add_sub(ar, br, 1'b1); ex_im = add_sub(ai, bi, 1'b1); end
      OP_CONJ: ex_im = negate(ai);
      OP_NEG:  begin ex_re = negate(ar); ex_im = negate(ai); end
      default: ;
    endcase
  end

  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    case (state)
      IDLE: begin
        if (start) begin
          case (op)
            OP_MUL:  state_nxt = MUL0;
            OP_MAG2: state_nxt = SQ0;
            default: state_nxt = EXEC;
          endcase
        end
      end
      MUL0:    state_nxt = MUL1;
      MUL1:    state_nxt = MUL2;
      MUL2:    state_nxt = MUL3;
      SQ0:     state_nxt = SQ1;
      default: state_nxt = IDLE;
    endcase
  end

  assign wen = done;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      op_q   <= '0;
      ar     <= '0;
      ai     <= '0;
      br     <= '0;
      bi     <= '0;
      acc_re <= '0;
      acc_im <= '0;
      done   <= 1'b0;
      wsel   <= '0;
      result <= '0;
      ovf    <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_q   <= op;
            ar     <= opA[63:32];
            ai     <= opA[31:0];
            br     <= opB[63:32];
            bi     <= opB[31:0];
            wsel   <= dsel;
            ovf    <= 1'b0;
            acc_re <= '0;
            acc_im <= '0;
          end
        end
        EXEC: begin
          result <= {ex_re[31:0], ex_im[31:0]};
          ovf    <= ex_re[32] | ex_im[32];
          done   <= 1'b1;
        end
        MUL3, SQ1: begin
          acc_re <= re_nxt;
          acc_im <= im_nxt;
          result <= {fin_re[31:0], fin_im[31:0]};
          ovf    <= fin_re[32] | fin_im[32];
          done   <= 1'b1;
        end
        default: begin
          acc_re <= re_nxt;
          acc_im <= im_nxt;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_complex_alu.sv
// Directed bench for complex_alu: vector table for every opcode and boundary,
// plus hand sequences for start-while-busy, back-to-back accept and mid-op reset.
module tb_complex_alu;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op    = '0;
  logic [63:0] opA   = '0;
  logic [63:0] opB   = '0;
  logic [3:0]  dsel  = '0;

  logic        busy, done, wen, ovf;
  logic [3:0]  wsel;
  logic [63:0] result;
  logic        busy16, done16, wen16, ovf16;
  logic [3:0]  wsel16;
  logic [63:0] result16;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  complex_alu #(.FRAC(0)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op), .opA(opA), .opB(opB),
    .dsel(dsel), .busy(busy), .done(done), .wen(wen), .wsel(wsel),
    .result(result), .ovf(ovf)
  );

  complex_alu #(.FRAC(16)) dut16 (
    .clock(clock), .reset(reset), .start(start), .op(op), .opA(opA), .opB(opB),
    .dsel(dsel), .busy(busy16), .done(done16), .wen(wen16), .wsel(wsel16),
    .result(result16), .ovf(ovf16)
  );

  typedef struct {
    logic [2:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic        use16;
    logic [63:0] res;
    logic        ovf;
    int          lat;
  } vec_t;

  vec_t vecs[16];

  function automatic vec_t mk(input logic [2:0] o, input logic [63:0] a, input logic [63:0] b,
                              input logic u16, input logic [63:0] r, input logic v, input int l);
    vec_t t;
    t.op = o; t.a = a; t.b = b; t.use16 = u16; t.res = r; t.ovf = v; t.lat = l;
    return t;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int id, input logic [3:0] ds);
    int lat;
    logic d, r_wen, r_busy, r_ovf;
    logic [3:0] r_wsel;
    logic [63:0] r_res;
    lat = 0;
    @(negedge clock);
    start = 1'b1; op = v.op; opA = v.a; opB = v.b; dsel = ds;
    @(posedge clock); #1;
    start = 1'b0; op = 3'b000; opA = ~v.a; opB = ~v.b; dsel = ~ds;
    for (int c = 1; c <= 10; c++) begin
      if (lat == 0) begin
        @(posedge clock); #1;
        d = v.use16 ? done16 : done;
        if (d) lat = c;
        else check($sformatf("vec%0d_busy_c%0d", id, c), {63'd0, (v.use16 ? busy16 : busy)}, 64'd1);
      end
    end
    r_res  = v.use16 ? result16 : result;
    r_ovf  = v.use16 ? ovf16 : ovf;
    r_wen  = v.use16 ? wen16 : wen;
    r_busy = v.use16 ? busy16 : busy;
    r_wsel = v.use16 ? wsel16 : wsel;
    check($sformatf("vec%0d_latency", id), 64'(lat), 64'(v.lat));
    check($sformatf("vec%0d_result", id), r_res, v.res);
    check($sformatf("vec%0d_ovf", id), {63'd0, r_ovf}, {63'd0, v.ovf});
    check($sformatf("vec%0d_wen", id), {63'd0, r_wen}, 64'd1);
    check($sformatf("vec%0d_busy_at_done", id), {63'd0, r_busy}, 64'd0);
    check($sformatf("vec%0d_wsel", id), {60'd0, r_wsel}, {60'd0, ds});
    @(posedge clock); #1;
    check($sformatf("vec%0d_done_pulse", id), {63'd0, (v.use16 ? done16 : done)}, 64'd0);
    check($sformatf("vec%0d_result_hold", id), (v.use16 ? result16 : result), v.res);
  endtask

  initial begin
    vec_t add_v;
    int   got;

    vecs[0]  = mk(3'b010, 64'h00000003_00000004, 64'h00000001_FFFFFFFE, 1'b0, 64'h0000000B_FFFFFFFE, 1'b0, 4);
    vecs[1]  = mk(3'b010, 64'h00018000_00000000, 64'h00020000_00000000, 1'b1, 64'h00030000_00000000, 1'b0, 4);
    vecs[2]  = mk(3'b010, 64'h7FFFFFFF_00000000, 64'h00000002_00000000, 1'b0, 64'hFFFFFFFE_00000000, 1'b1, 4);
    vecs[3]  = mk(3'b000, 64'h7FFFFFFF_00000005, 64'h00000001_00000007, 1'b0, 64'h80000000_0000000C, 1'b1, 1);
    vecs[4]  = mk(3'b101, 64'h80000000_00000001, 64'h0, 1'b0, 64'h80000000_FFFFFFFF, 1'b1, 1);
    vecs[5]  = mk(3'b100, 64'h00000003_00000004, 64'h0, 1'b0, 64'h00000019_00000000, 1'b0, 2);
    vecs[6]  = mk(3'b011, 64'h00000003_00000004, 64'h0, 1'b0, 64'h00000003_FFFFFFFC, 1'b0, 1);
    vecs[7]  = mk(3'b001, 64'h00000005_80000000, 64'h00000007_00000001, 1'b0, 64'hFFFFFFFE_7FFFFFFF, 1'b1, 1);
    vecs[8]  = mk(3'b110, 64'h12345678_9ABCDEF0, 64'h11111111_22222222, 1'b0, 64'h12345678_9ABCDEF0, 1'b0, 1);
    vecs[9]  = mk(3'b111, 64'hCAFEBABE_00000001, 64'h0, 1'b0, 64'hCAFEBABE_00000001, 1'b0, 1);
    vecs[10] = mk(3'b001, 64'h0000000A_00000014, 64'h00000003_00000005, 1'b0, 64'h00000007_0000000F, 1'b0, 1);
    vecs[11] = mk(3'b010, 64'hFFFFFFFE_00000003, 64'h00000004_FFFFFFFB, 1'b0, 64'h00000007_00000016, 1'b0, 4);
    vecs[12] = mk(3'b010, 64'hFFFF8000_00000000, 64'h00000001_00000000, 1'b1, 64'hFFFFFFFF_00000000, 1'b0, 4);
    vecs[13] = mk(3'b100, 64'h80000000_00000000, 64'h0, 1'b0, 64'h00000000_00000000, 1'b1, 2);
    vecs[14] = mk(3'b101, 64'h00000005_FFFFFFFD, 64'h0, 1'b0, 64'hFFFFFFFB_00000003, 1'b0, 1);
    vecs[15] = mk(3'b011, 64'h00000001_80000000, 64'h0, 1'b0, 64'h00000001_80000000, 1'b1, 1);

    // Reset state
    #1;
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_wen", {63'd0, wen}, 64'd0);
    check("rst_wsel", {60'd0, wsel}, 64'd0);
    check("rst_result", result, 64'd0);
    check("rst_ovf", {63'd0, ovf}, 64'd0);
    repeat (2) @(negedge clock);
    reset = 1'b1;

    for (int i = 0; i < 16; i++) run_vec(vecs[i], i, 4'(i + 3));

    // start pulses with ADD while MUL is busy are ignored; start held into done cycle is accepted
    @(negedge clock);
    start = 1'b1; op = 3'b010; opA = 64'h00000003_00000004; opB = 64'h00000001_FFFFFFFE; dsel = 4'h5;
    @(posedge clock); #1;
    op = 3'b000; opA = 64'h00000001_00000001; opB = 64'h00000002_00000002; dsel = 4'h9;
    got = 0;
    for (int c = 1; c <= 10; c++) begin
      if (got == 0) begin
        @(posedge clock); #1;
        if (done) got = c;
      end
    end
    check("busy_mul_latency", 64'(got), 64'd4);
    check("busy_mul_result", result, 64'h0000000B_FFFFFFFE);
    check("busy_mul_wsel", {60'd0, wsel}, 64'd5);
    check("busy_mul_ovf", {63'd0, ovf}, 64'd0);
    @(posedge clock); #1;
    start = 1'b0;
    check("b2b_accept_busy", {63'd0, busy}, 64'd1);
    check("b2b_accept_wsel", {60'd0, wsel}, 64'd9);
    @(posedge clock); #1;
    check("b2b_done", {63'd0, done}, 64'd1);
    check("b2b_result", result, 64'h00000003_00000003);

    // Reset during MUL1 aborts with all outputs cleared
    @(negedge clock);
    start = 1'b1; op = 3'b010; opA = 64'h00000003_00000004; opB = 64'h00000001_FFFFFFFE; dsel = 4'hA;
    @(posedge clock); #1;
    start = 1'b0;
    @(posedge clock); #1;
    check("mid_busy_before_rst", {63'd0, busy}, 64'd1);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_busy", {63'd0, busy}, 64'd0);
    check("mid_rst_done", {63'd0, done}, 64'd0);
    check("mid_rst_wen", {63'd0, wen}, 64'd0);
    check("mid_rst_wsel", {60'd0, wsel}, 64'd0);
    check("mid_rst_result", result, 64'd0);
    check("mid_rst_ovf", {63'd0, ovf}, 64'd0);
    got = 0;
    repeat (3) begin
      @(posedge clock); #1;
      if (done) got++;
    end
    @(negedge clock);
    reset = 1'b1;
    repeat (5) begin
      @(posedge clock); #1;
      if (done || busy) got++;
    end
    check("mid_rst_no_done", 64'(got), 64'd0);

    add_v = mk(3'b000, 64'h00000001_00000001, 64'h00000002_00000002, 1'b0, 64'h00000003_00000003, 1'b0, 1);
    run_vec(add_v, 99, 4'h2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
